cache_bank_sched: RTL and testbench
===================================

# cache_bank_sched

Input scheduler for one cache bank, placed directly upstream of the bank's st0 stage. Each cycle it picks one request from four sources and registers it into a single-entry output stage that feeds st0: a memory fill, an MSHR replay (dequeue), a flush-sweep line, or a new core request. Fills have fixed top priority. A starvation counter guarantees core requests progress under sustained replay traffic. Core requests are admitted only when the MSHR can allocate.

## Interface
- LINE_ADDR_WIDTH, 26, line address width
- LINE_WIDTH, 128, fill/line data width; width of out_data
- WORD_WIDTH, 64, core/replay payload width (≤ LINE_WIDTH)
- MSHR_ADDR_WIDTH, 2, MSHR id width
- TAG_WIDTH, 8, core request tag width
- NUM_LINES, 64, lines swept per flush (power of two)
- STARVE_LIMIT, 4, consecutive lost core cycles before forced core grant (≥1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fill_valid / fill_ready  in/out  1  memory fill handshake
- fill_id  in  MSHR_ADDR_WIDTH  MSHR entry being filled
- fill_addr  in  LINE_ADDR_WIDTH  line address of fill_id
- fill_data  in  LINE_WIDTH  fill line data
- replay_valid / replay_ready  in/out  1  MSHR dequeue handshake
- replay_id  in  MSHR_ADDR_WIDTH; replay_addr  in  LINE_ADDR_WIDTH; replay_rw  in  1; replay_data  in  WORD_WIDTH
- core_valid / core_ready  in/out  1  core request handshake
- core_addr  in  LINE_ADDR_WIDTH; core_rw  in  1; core_data  in  WORD_WIDTH; core_tag  in  TAG_WIDTH
- mshr_alloc_ready  in  1  MSHR has a free entry
- flush_valid / flush_ready  in/out  1  flush start handshake
- flush_done  out  1  one-cycle pulse when the last sweep line leaves the output stage
- out_valid / out_ready  out/in  1  st0 handshake
- out_op  out  2  0=core, 1=replay, 2=fill, 3=flush
- out_addr  out  LINE_ADDR_WIDTH; out_rw  out  1; out_data  out  LINE_WIDTH; out_id  out  MSHR_ADDR_WIDTH; out_tag  out  TAG_WIDTH

## Operation
- load = ~out_valid | out_ready. No grant is made when load=0.
- Priority when load=1:
  - fill
  - core, if starve_force
  - replay
  - flush line, if state=FLUSH
  - core, if state=IDLE and mshr_alloc_ready
- Ready outputs:
  - fill_ready = load.
  - replay_ready = load & ~fill_valid & ~starve_force.
  - core_ready = load & ~fill_valid & (starve_force | ~replay_valid) & state==IDLE & mshr_alloc_ready.
- starve_force = (starve_cnt == STARVE_LIMIT) & state==IDLE & mshr_alloc_ready.
- starve_cnt update:
  - increments, saturating at STARVE_LIMIT, on cycles where core_valid & mshr_alloc_ready & state==IDLE & load & ~core_ready;
  - clears on a core grant or when core_valid=0.
- Payload packing into the output register:
  - core/replay: data zero-extended to LINE_WIDTH.
  - fill: out_data=fill_data, out_rw=0.
  - flush: out_addr = zero-extended sweep index, out_rw=0, out_data=0.
  - out_id: fill_id/replay_id for fill/replay ops, else 0.
  - out_tag: core_tag for core ops, else 0.
- FSM states:
  - IDLE: flush_ready=1. On flush_valid, go to FLUSH with idx=0.
  - FLUSH: issues one line per flush grant and increments idx. Core is blocked; fill and replay still win. The grant with idx=NUM_LINES-1 moves to DRAIN.
  - DRAIN: when the held flush op is accepted (out_valid & out_ready & out_op==3), pulse flush_done and return to IDLE.
- flush_ready=0 outside IDLE. flush_valid is ignored outside IDLE.

## Timing
- Grant to out_valid latency: 1 cycle (registered output). Full throughput: one op per cycle while out_ready=1.
- Output payload is held stable while out_valid & ~out_ready.
- Reset values:
  - out_valid=0, all out_* fields=0, flush_done=0;
  - state=IDLE, idx=0, starve_cnt=0;
  - flush_ready=1 from the first cycle after reset deasserts.
- Reset during FLUSH/DRAIN aborts the sweep immediately. No flush_done is produced.
- Ready outputs are combinational from inputs and state. valid must not depend on ready.
- fill_valid and replay_valid both high: fill wins and replay_ready=0. Replay is granted the next cycle if still valid.
- idx wraps to 0 only via the IDLE→FLUSH transition, never by overflow.

## Test plan
- Fill and replay and core all valid, out_ready=1, mshr_alloc_ready=1 → cycle N+1 out_op=2; N+2 out_op=1; N+3 out_op=0.
- replay_valid held high, core_valid high, STARVE_LIMIT=4 → replays granted for 4 cycles, core granted in the 5th; starve_cnt then 0.
- out_ready=0 for 3 cycles with out_valid=1 → all readys 0, out_* unchanged; first op accepted on the cycle out_ready returns.
- flush_valid with NUM_LINES=4 → out_op=3 with out_addr 0,1,2,3 in consecutive cycles; core_ready=0 throughout; flush_done pulses for exactly one cycle, on the cycle the addr=3 op is accepted; flush_ready returns to 1.
- During flush, fill at sweep idx=2 → fill inserted between addr 1 and 2; sweep resumes without skipping or repeating a line.
- mshr_alloc_ready=0 with core_valid=1 → core_ready=0, no grant, starve_cnt stays 0. Reset asserted mid-flush → out_valid=0 and flush_ready=1 on the cycle after reset drops; no flush_done.

Source files
------------

// File: rtl/cache_bank_sched_if.sv
// ----------------------------------------------------------------------------
// cache_bank_sched_if
//   Bundles every handshake and payload signal of the cache bank input
//   scheduler: memory fill, MSHR replay, core request, MSHR allocation status,
//   flush start/done, the st0 output stage, and a small debug view of the
//   scheduler's internal state.
//
//   Modports:
//     master : environment side (fill/replay/core/flush sources, st0 sink)
//     slave  : scheduler side (cache_bank_sched)
//
//   Handshake rule for every valid/ready pair: a transfer happens on a rising
//   clk edge where valid and ready are both 1; valid never waits for ready,
//   and the payload of the valid side is stable while valid & ~ready.
// ----------------------------------------------------------------------------
interface cache_bank_sched_if #(
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int LINE_WIDTH      = 128,
   parameter int WORD_WIDTH      = 64,
   parameter int MSHR_ADDR_WIDTH = 2,
   parameter int TAG_WIDTH       = 8,
   parameter int NUM_LINES       = 64,
   parameter int STARVE_LIMIT    = 4
);
   localparam int IDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   // memory fill
   logic                       fill_valid;
   logic                       fill_ready;
   logic [MSHR_ADDR_WIDTH-1:0] fill_id;
   logic [LINE_ADDR_WIDTH-1:0] fill_addr;
   logic [LINE_WIDTH-1:0]      fill_data;

   // MSHR replay
   logic                       replay_valid;
   logic                       replay_ready;
   logic [MSHR_ADDR_WIDTH-1:0] replay_id;
   logic [LINE_ADDR_WIDTH-1:0] replay_addr;
   logic                       replay_rw;
   logic [WORD_WIDTH-1:0]      replay_data;

   // core request
   logic                       core_valid;
   logic                       core_ready;
   logic [LINE_ADDR_WIDTH-1:0] core_addr;
   logic                       core_rw;
   logic [WORD_WIDTH-1:0]      core_data;
   logic [TAG_WIDTH-1:0]       core_tag;

   logic                       mshr_alloc_ready;

   // flush control
   logic                       flush_valid;
   logic                       flush_ready;
   logic                       flush_done;

   // st0 output stage
   logic                       out_valid;
   logic                       out_ready;
   logic [1:0]                 out_op;
   logic [LINE_ADDR_WIDTH-1:0] out_addr;
   logic                       out_rw;
   logic [LINE_WIDTH-1:0]      out_data;
   logic [MSHR_ADDR_WIDTH-1:0] out_id;
   logic [TAG_WIDTH-1:0]       out_tag;

   // debug view: FSM state (0=IDLE,1=FLUSH,2=DRAIN), sweep index, starve count
   logic [1:0]                 dbg_state;
   logic [IDX_W-1:0]           dbg_idx;
   logic [STARVE_W-1:0]        dbg_starve_cnt;

   modport master (
      output fill_valid, fill_id, fill_addr, fill_data,
      output replay_valid, replay_id, replay_addr, replay_rw, replay_data,
      output core_valid, core_addr, core_rw, core_data, core_tag,
      output mshr_alloc_ready, flush_valid, out_ready,
      input  fill_ready, replay_ready, core_ready, flush_ready, flush_done,
      input  out_valid, out_op, out_addr, out_rw, out_data, out_id, out_tag,
      input  dbg_state, dbg_idx, dbg_starve_cnt
   );

   modport slave (
      input  fill_valid, fill_id, fill_addr, fill_data,
      input  replay_valid, replay_id, replay_addr, replay_rw, replay_data,
      input  core_valid, core_addr, core_rw, core_data, core_tag,
      input  mshr_alloc_ready, flush_valid, out_ready,
      output fill_ready, replay_ready, core_ready, flush_ready, flush_done,
      output out_valid, out_op, out_addr, out_rw, out_data, out_id, out_tag,
      output dbg_state, dbg_idx, dbg_starve_cnt
   );
endinterface

// File: rtl/cache_bank_sched.sv
// ----------------------------------------------------------------------------
// cache_bank_sched
//   Input scheduler for one cache bank, feeding the bank's st0 stage. Every
//   cycle the single-entry output register can load, it grants at most one of:
//     fill (always first), core (when starved), replay, flush sweep line,
//     core (normal, only in IDLE with a free MSHR entry).
//   A starvation counter forces a core grant after STARVE_LIMIT consecutive
//   cycles in which an eligible core request lost arbitration.
//   A flush walks line indices 0..NUM_LINES-1 as op 3, then waits for the last
//   sweep op to be accepted by st0 and pulses flush_done.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high
//     bus    : cache_bank_sched_if.slave (all handshakes, payloads, debug)
//
//   out_op encoding: 0=core, 1=replay, 2=fill, 3=flush.
// ----------------------------------------------------------------------------
module cache_bank_sched #(
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int LINE_WIDTH      = 128,
   parameter int WORD_WIDTH      = 64,
   parameter int MSHR_ADDR_WIDTH = 2,
   parameter int TAG_WIDTH       = 8,
   parameter int NUM_LINES       = 64,
   parameter int STARVE_LIMIT    = 4
) (
   input logic               clk,
   input logic               reset,
   cache_bank_sched_if.slave bus
);
   localparam int IDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_LINES - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   localparam logic [1:0] OP_CORE   = 2'd0;
   localparam logic [1:0] OP_REPLAY = 2'd1;
   localparam logic [1:0] OP_FILL   = 2'd2;
   localparam logic [1:0] OP_FLUSH  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [STARVE_W-1:0] starve_cnt;

   logic load;
   logic in_idle;
   logic starve_force;
   logic fill_go;
   logic replay_go;
   logic core_go;
   logic sweep_go;
   logic grant_any;
   logic last_accept;

   // ------------------------------------------------------------------------
   // Arbitration. The output register can take a new op when it is empty or
   // its current op leaves this cycle.
   // ------------------------------------------------------------------------
   assign load         = ~bus.out_valid | bus.out_ready;
   assign in_idle      = (state == ST_IDLE);
   assign starve_force = (starve_cnt == STARVE_MAX) & in_idle & bus.mshr_alloc_ready;

   assign bus.fill_ready   = load;
   assign bus.replay_ready = load & ~bus.fill_valid & ~starve_force;
   assign bus.core_ready   = load & ~bus.fill_valid & (starve_force | ~bus.replay_valid)
                             & in_idle & bus.mshr_alloc_ready;

   // The four grants are mutually exclusive by construction of the readys;
   // a sweep line only goes out when nothing with higher priority is pending
   // (starve_force is always 0 outside IDLE).
   assign fill_go   = bus.fill_valid & bus.fill_ready;
   assign replay_go = bus.replay_valid & bus.replay_ready;
   assign core_go   = bus.core_valid & bus.core_ready;
   assign sweep_go  = load & (state == ST_FLUSH) & ~bus.fill_valid & ~bus.replay_valid;
   assign grant_any = fill_go | replay_go | core_go | sweep_go;

   // The last sweep op leaves st0's input register.
   assign last_accept = bus.out_valid & bus.out_ready & (bus.out_op == OP_FLUSH);

   // ------------------------------------------------------------------------
   // Flush FSM: state register / next state / outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.flush_valid) state_nxt = ST_FLUSH;
         ST_FLUSH: if (sweep_go && (idx == LAST_IDX)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (last_accept) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.flush_ready = (state == ST_IDLE);
      // Gated by reset so an aborted sweep never reports completion.
      bus.flush_done  = ~reset & (state == ST_DRAIN) & last_accept;
   end

   // Sweep index: restarts on flush start, advances per sweep grant and
   // parks on the last line (never wraps by overflow).
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (in_idle && bus.flush_valid) begin
         idx <= '0;
      end else if (sweep_go && (idx != LAST_IDX)) begin
         idx <= idx + 1'b1;
      end
   end

   // Starvation counter: counts cycles where an eligible core request could
   // have been loaded but lost arbitration.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (core_go || !bus.core_valid) begin
         starve_cnt <= '0;
      end else if (bus.mshr_alloc_ready && in_idle && load && !bus.core_ready
                   && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output register. Payload only changes on a grant, so it is held while
   // out_valid & ~out_ready (load=0 then).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_op    <= '0;
         bus.out_addr  <= '0;
         bus.out_rw    <= 1'b0;
         bus.out_data  <= '0;
         bus.out_id    <= '0;
         bus.out_tag   <= '0;
      end else if (load) begin
         bus.out_valid <= grant_any;
         if (fill_go) begin
            bus.out_op   <= OP_FILL;
            bus.out_addr <= bus.fill_addr;
            bus.out_rw   <= 1'b0;
            bus.out_data <= bus.fill_data;
            bus.out_id   <= bus.fill_id;
            bus.out_tag  <= '0;
         end else if (replay_go) begin
            bus.out_op   <= OP_REPLAY;
            bus.out_addr <= bus.replay_addr;
            bus.out_rw   <= bus.replay_rw;
            bus.out_data <= LINE_WIDTH'(bus.replay_data);
            bus.out_id   <= bus.replay_id;
            bus.out_tag  <= '0;
         end else if (core_go) begin
            bus.out_op   <= OP_CORE;
            bus.out_addr <= bus.core_addr;
            bus.out_rw   <= bus.core_rw;
            bus.out_data <= LINE_WIDTH'(bus.core_data);
            bus.out_id   <= '0;
            bus.out_tag  <= bus.core_tag;
         end else if (sweep_go) begin
            bus.out_op   <= OP_FLUSH;
            bus.out_addr <= LINE_ADDR_WIDTH'(idx);
            bus.out_rw   <= 1'b0;
            bus.out_data <= '0;
            bus.out_id   <= '0;
            bus.out_tag  <= '0;
         end
      end
   end

   // Debug view
   assign bus.dbg_state      = state;
   assign bus.dbg_idx        = idx;
   assign bus.dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_cache_bank_sched.sv
// ----------------------------------------------------------------------------
// tb_cache_bank_sched
//   Directed bench for cache_bank_sched with NUM_LINES=4, STARVE_LIMIT=4.
//   A negedge process holds a behavioural model (mode, sweep line, lost-cycle
//   count, and an expected-op queue standing for the output stage) and checks
//   every DUT output each cycle; directed sections pin the model with
//   hand-computed accepted-op sequences.
// ----------------------------------------------------------------------------
module tb_cache_bank_sched;
   localparam int LAW = 26;
   localparam int LW  = 128;
   localparam int WW  = 64;
   localparam int MAW = 2;
   localparam int TW  = 8;
   localparam int NL  = 4;
   localparam int SL  = 4;
   localparam int PW  = 2 + LAW + 1 + LW + MAW + TW;

   localparam int M_IDLE  = 0;
   localparam int M_FLUSH = 1;
   localparam int M_DRAIN = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_bank_sched_if #(
      .LINE_ADDR_WIDTH(LAW), .LINE_WIDTH(LW), .WORD_WIDTH(WW),
      .MSHR_ADDR_WIDTH(MAW), .TAG_WIDTH(TW), .NUM_LINES(NL), .STARVE_LIMIT(SL)
   ) bus ();

   cache_bank_sched #(
      .LINE_ADDR_WIDTH(LAW), .LINE_WIDTH(LW), .WORD_WIDTH(WW),
      .MSHR_ADDR_WIDTH(MAW), .TAG_WIDTH(TW), .NUM_LINES(NL), .STARVE_LIMIT(SL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic [PW-1:0]  exp_q[$];
   int             m_mode = M_IDLE;
   int             m_sweep = 0;
   int             m_lost = 0;

   int             acc_op[$];
   logic [LAW-1:0] acc_addr[$];
   int             done_cnt = 0;
   logic [LAW-1:0] done_addr = '0;

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_log(input string name, input int i, input int op, input logic [LAW-1:0] addr);
      total++;
      if (i >= acc_op.size()) begin
         bad++;
         $display("FAIL %s[%0d]: got no op (log size %0d) expected op %0d addr %0h",
                  name, i, acc_op.size(), op, addr);
      end else if (acc_op[i] != op || acc_addr[i] !== addr) begin
         bad++;
         $display("FAIL %s[%0d]: got op %0d addr %0h expected op %0d addr %0h",
                  name, i, acc_op[i], acc_addr[i], op, addr);
      end
   endtask

   function automatic logic [PW-1:0] pack(input logic [1:0] op, input logic [LAW-1:0] a,
                                          input logic rw, input logic [LW-1:0] d,
                                          input logic [MAW-1:0] id, input logic [TW-1:0] tag);
      return {op, a, rw, d, id, tag};
   endfunction

   // ---------------- model + compare (negedge) ----------------
   bit             m_has, m_load, m_idle, m_force;
   bit             e_fill_r, e_rep_r, e_core_r, e_flush_r, e_done;
   int             winner;   // -1 none, 0 core, 1 replay, 2 fill, 3 flush
   logic [PW-1:0]  head, item, dut_pack;
   logic [1:0]     head_op;
   logic [LW-1:0]  zd;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_mode  = M_IDLE;
         m_sweep = 0;
         m_lost  = 0;
      end else begin
         m_has   = (exp_q.size() != 0);
         head    = m_has ? exp_q[0] : '0;
         head_op = head[PW-1 -: 2];
         m_load  = !m_has || bus.out_ready;
         m_idle  = (m_mode == M_IDLE);
         m_force = (m_lost == SL) && m_idle && bus.mshr_alloc_ready;

         e_fill_r  = m_load;
         e_rep_r   = m_load && !bus.fill_valid && !m_force;
         e_core_r  = m_load && !bus.fill_valid && (m_force || !bus.replay_valid)
                     && m_idle && bus.mshr_alloc_ready;
         e_flush_r = m_idle;
         e_done    = (m_mode == M_DRAIN) && m_has && bus.out_ready && (head_op == 2'd3);

         chk("fill_ready",   PW'(bus.fill_ready),   PW'(e_fill_r));
         chk("replay_ready", PW'(bus.replay_ready), PW'(e_rep_r));
         chk("core_ready",   PW'(bus.core_ready),   PW'(e_core_r));
         chk("flush_ready",  PW'(bus.flush_ready),  PW'(e_flush_r));
         chk("flush_done",   PW'(bus.flush_done),   PW'(e_done));
         chk("out_valid",    PW'(bus.out_valid),    PW'(m_has));
         chk("starve_cnt",   PW'(bus.dbg_starve_cnt), PW'(m_lost));
         if (m_has) begin
            dut_pack = pack(bus.out_op, bus.out_addr, bus.out_rw, bus.out_data, bus.out_id, bus.out_tag);
            chk("out_payload", dut_pack, head);
         end

         if (bus.out_valid && bus.out_ready) begin
            acc_op.push_back(int'(bus.out_op));
            acc_addr.push_back(bus.out_addr);
         end
         if (bus.flush_done) begin
            done_cnt++;
            done_addr = bus.out_addr;
         end

         // choose this cycle's grant from the priority list
         winner = -1;
         if (m_load) begin
            if (bus.fill_valid)                     winner = 2;
            else if (m_force) begin
               if (bus.core_valid)                  winner = 0;
            end
            else if (bus.replay_valid)              winner = 1;
            else if (m_mode == M_FLUSH)             winner = 3;
            else if (bus.core_valid && m_idle && bus.mshr_alloc_ready) winner = 0;
         end

         if (m_has && bus.out_ready) void'(exp_q.pop_front());
         if (winner >= 0) begin
            zd = '0;
            case (winner)
               0: begin
                  zd[WW-1:0] = bus.core_data;
                  item = pack(2'd0, bus.core_addr, bus.core_rw, zd, '0, bus.core_tag);
               end
               1: begin
                  zd[WW-1:0] = bus.replay_data;
                  item = pack(2'd1, bus.replay_addr, bus.replay_rw, zd, bus.replay_id, '0);
               end
               2: item = pack(2'd2, bus.fill_addr, 1'b0, bus.fill_data, bus.fill_id, '0);
               default: item = pack(2'd3, LAW'(m_sweep), 1'b0, '0, '0, '0);
            endcase
            exp_q.push_back(item);
         end

         if (!bus.core_valid || winner == 0) m_lost = 0;
         else if (bus.mshr_alloc_ready && m_idle && m_load && !e_core_r)
            m_lost = (m_lost < SL) ? m_lost + 1 : SL;

         case (m_mode)
            M_IDLE: if (bus.flush_valid) begin
               m_mode  = M_FLUSH;
               m_sweep = 0;
            end
            M_FLUSH: if (winner == 3) begin
               if (m_sweep == NL - 1) m_mode = M_DRAIN;
               else m_sweep = m_sweep + 1;
            end
            default: if (e_done) m_mode = M_IDLE;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fill_valid   = 1'b0; bus.fill_id = '0; bus.fill_addr = '0; bus.fill_data = '0;
      bus.replay_valid = 1'b0; bus.replay_id = '0; bus.replay_addr = '0;
      bus.replay_rw    = 1'b0; bus.replay_data = '0;
      bus.core_valid   = 1'b0; bus.core_addr = '0; bus.core_rw = 1'b0;
      bus.core_data    = '0; bus.core_tag = '0;
      bus.flush_valid  = 1'b0;
   endtask

   task automatic clear_log();
      acc_op.delete();
      acc_addr.delete();
   endtask

   // ---------------- timeout ----------------
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish by %0t", $time);
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   int d0;

   initial begin
      idle_inputs();
      bus.out_ready = 1'b1;
      bus.mshr_alloc_ready = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      // reset values
      chk("rst_out_valid",   PW'(bus.out_valid),   PW'(0));
      chk("rst_out_addr",    PW'(bus.out_addr),    PW'(0));
      chk("rst_out_data",    PW'(bus.out_data),    PW'(0));
      chk("rst_flush_ready", PW'(bus.flush_ready), PW'(1));
      chk("rst_flush_done",  PW'(bus.flush_done),  PW'(0));
      chk("rst_starve",      PW'(bus.dbg_starve_cnt), PW'(0));
      tick();

      // fill > replay > core
      clear_log();
      bus.fill_valid = 1'b1; bus.fill_addr = 26'h123; bus.fill_id = 2'd2;
      bus.fill_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      bus.replay_valid = 1'b1; bus.replay_addr = 26'h200; bus.replay_id = 2'd1;
      bus.replay_rw = 1'b1; bus.replay_data = 64'hAAAA_5555_AAAA_5555;
      bus.core_valid = 1'b1; bus.core_addr = 26'h300; bus.core_rw = 1'b1;
      bus.core_data = 64'h0123_4567_89AB_CDEF; bus.core_tag = 8'h5A;
      tick(); bus.fill_valid = 1'b0;
      tick(); bus.replay_valid = 1'b0;
      tick(); bus.core_valid = 1'b0;
      tick(); tick();
      chk_log("prio", 0, 2, 26'h123);
      chk_log("prio", 1, 1, 26'h200);
      chk_log("prio", 2, 0, 26'h300);

      // starvation: 4 replays then forced core
      clear_log();
      bus.replay_valid = 1'b1; bus.replay_addr = 26'h210; bus.replay_id = 2'd3;
      bus.core_valid = 1'b1; bus.core_addr = 26'h310; bus.core_tag = 8'h11;
      repeat (4) tick();
      chk("starve_at_limit", PW'(bus.dbg_starve_cnt), PW'(4));
      tick();
      bus.core_valid = 1'b0; bus.replay_valid = 1'b0;
      chk("starve_cleared", PW'(bus.dbg_starve_cnt), PW'(0));
      tick(); tick();
      for (int i = 0; i < 4; i++) chk_log("starve", i, 1, 26'h210);
      chk_log("starve", 4, 0, 26'h310);

      // backpressure: output held for 3 cycles
      clear_log();
      bus.out_ready = 1'b0;
      bus.core_valid = 1'b1; bus.core_addr = 26'h3A0; bus.core_tag = 8'h22;
      tick();
      bus.core_addr = 26'h3A1;
      bus.fill_valid = 1'b1; bus.fill_addr = 26'h1F0;
      bus.replay_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_fill_ready", PW'(bus.fill_ready), PW'(0));
         chk("stall_core_ready", PW'(bus.core_ready), PW'(0));
         chk("stall_out_addr",   PW'(bus.out_addr),   PW'(26'h3A0));
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.fill_valid = 1'b0; bus.replay_valid = 1'b0; bus.core_valid = 1'b0;
      tick(); tick();
      chk_log("stall", 0, 0, 26'h3A0);
      chk_log("stall", 1, 2, 26'h1F0);

      // flush sweep of 4 lines, core blocked until done
      clear_log();
      d0 = done_cnt;
      bus.flush_valid = 1'b1;
      tick();
      bus.flush_valid = 1'b0;
      chk("flush_busy_ready", PW'(bus.flush_ready), PW'(0));
      bus.core_valid = 1'b1; bus.core_addr = 26'h3C0;
      repeat (6) tick();
      bus.core_valid = 1'b0;
      tick(); tick();
      for (int i = 0; i < 4; i++) chk_log("sweep", i, 3, LAW'(i));
      chk_log("sweep", 4, 0, 26'h3C0);
      chk("sweep_done_cnt",  PW'(done_cnt),  PW'(d0 + 1));
      chk("sweep_done_addr", PW'(done_addr), PW'(3));
      chk("sweep_flush_ready", PW'(bus.flush_ready), PW'(1));

      // fill lands between sweep lines 1 and 2
      clear_log();
      bus.flush_valid = 1'b1;
      tick();
      bus.flush_valid = 1'b0;
      tick(); tick();
      bus.fill_valid = 1'b1; bus.fill_addr = 26'h1E0; bus.fill_id = 2'd1;
      tick();
      bus.fill_valid = 1'b0;
      repeat (5) tick();
      chk_log("sweep_fill", 0, 3, 26'h0);
      chk_log("sweep_fill", 1, 3, 26'h1);
      chk_log("sweep_fill", 2, 2, 26'h1E0);
      chk_log("sweep_fill", 3, 3, 26'h2);
      chk_log("sweep_fill", 4, 3, 26'h3);
      chk("sweep_fill_done_cnt", PW'(done_cnt), PW'(d0 + 2));

      // no MSHR entry: core never admitted
      clear_log();
      bus.mshr_alloc_ready = 1'b0;
      bus.core_valid = 1'b1; bus.core_addr = 26'h3D0;
      repeat (3) tick();
      chk("nomshr_starve",    PW'(bus.dbg_starve_cnt), PW'(0));
      chk("nomshr_out_valid", PW'(bus.out_valid),      PW'(0));
      chk("nomshr_log",       PW'(acc_op.size()),      PW'(0));
      bus.core_valid = 1'b0;
      bus.mshr_alloc_ready = 1'b1;
      tick();

      // reset in the middle of a sweep
      d0 = done_cnt;
      bus.flush_valid = 1'b1;
      tick();
      bus.flush_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_out_valid",   PW'(bus.out_valid),   PW'(0));
      chk("midrst_flush_ready", PW'(bus.flush_ready), PW'(1));
      repeat (6) tick();
      chk("midrst_no_done", PW'(done_cnt), PW'(d0));

      // mixed traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         bus.fill_valid   = ($urandom_range(0, 7) == 0);
         bus.fill_addr    = LAW'($urandom);
         bus.fill_id      = MAW'($urandom_range(0, 3));
         bus.fill_data    = {$urandom, $urandom, $urandom, $urandom};
         bus.replay_valid = ($urandom_range(0, 2) == 0);
         bus.replay_addr  = LAW'($urandom);
         bus.replay_id    = MAW'($urandom_range(0, 3));
         bus.replay_rw    = 1'($urandom_range(0, 1));
         bus.replay_data  = {$urandom, $urandom};
         bus.core_valid   = ($urandom_range(0, 3) != 0);
         bus.core_addr    = LAW'($urandom);
         bus.core_rw      = 1'($urandom_range(0, 1));
         bus.core_data    = {$urandom, $urandom};
         bus.core_tag     = TW'($urandom);
         bus.mshr_alloc_ready = ($urandom_range(0, 3) != 0);
         bus.out_ready    = ($urandom_range(0, 3) != 0);
         bus.flush_valid  = ($urandom_range(0, 39) == 0);
         tick();
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      bus.mshr_alloc_ready = 1'b1;
      repeat (NL + 6) tick();
      chk("final_drained", PW'(bus.out_valid), PW'(0));
      chk("final_idle",    PW'(bus.flush_ready), PW'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
